// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_port_arbiter
// Brief   : Shares one single-port RAM between an SPI command stream and a
//           local requester, with round-robin tie breaking.
// Revision: 1.0  initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           spi_rx_data,
    input  logic                 spi_rx_valid,
    output logic [7:0]           spi_tx_data,
    output logic                 spi_tx_valid,
    output logic                 spi_ovf,
    input  logic                 loc_req,
    input  logic                 loc_we,
    input  logic [ADDR_SIZE-1:0] loc_addr,
    input  logic [7:0]           loc_wdata,
    output logic                 loc_gnt,
    output logic [7:0]           loc_rdata,
    output logic                 loc_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);

    localparam logic [1:0] c_OP_WADDR = 2'b00;
    localparam logic [1:0] c_OP_RADDR = 2'b10;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SPI_ACC = 2'd1;
    localparam logic [1:0] c_ST_LOC_ACC = 2'd2;
    localparam logic [1:0] c_ST_RD_RET  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic                 r_rx_q;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_spi_pend;
    logic                 r_pend_we;
    logic [ADDR_SIZE-1:0] r_pend_addr;
    logic [7:0]           r_pend_data;
    logic                 r_spi_ovf;
    logic                 r_last_spi;
    logic                 r_owner_spi;
    logic                 r_ram_en;
    logic                 r_ram_we;
    logic [ADDR_SIZE-1:0] r_ram_addr;
    logic [7:0]           r_ram_wdata;
    logic                 r_loc_gnt;
    logic [7:0]           r_loc_rdata;
    logic                 r_loc_rvalid;
    logic [7:0]           r_spi_tx_data;
    logic                 r_spi_tx_valid;

    logic [1:0]           w_op;
    logic [7:0]           w_pl;
    logic [ADDR_SIZE-1:0] w_pl_addr;
    logic                 w_accept;
    logic                 w_new_acc;
    logic                 w_new_we;
    logic [ADDR_SIZE-1:0] w_new_addr;
    logic                 w_spi_req;
    logic                 w_spi_we;
    logic [ADDR_SIZE-1:0] w_spi_addr;
    logic [7:0]           w_spi_wdata;
    logic                 w_spi_grant;
    logic                 w_loc_grant;
    logic                 w_drop;
    logic                 w_keep;
    logic                 w_store;
    logic                 w_ret;
    logic                 w_ram_en_d;
    logic                 w_ram_we_d;
    logic [ADDR_SIZE-1:0] w_ram_addr_d;
    logic [7:0]           w_ram_wdata_d;

    assign w_op     = spi_rx_data[9:8];
    assign w_pl     = spi_rx_data[7:0];
    assign w_accept = spi_rx_valid & ~r_rx_q;

    generate
        if (ADDR_SIZE <= 8) begin : g_addr_narrow
            assign w_pl_addr = w_pl[ADDR_SIZE-1:0];
        end else begin : g_addr_wide
            assign w_pl_addr = {{(ADDR_SIZE-8){1'b0}}, w_pl};
        end
    endgenerate

    // A freshly accepted access word bypasses spi_pend when the arbiter is idle
    assign w_new_acc   = w_accept & w_op[0] & ~r_spi_pend;
    assign w_new_we    = ~w_op[1];
    assign w_new_addr  = w_op[1] ? r_rd_addr : r_wr_addr;
    assign w_spi_req   = r_spi_pend | w_new_acc;
    assign w_spi_we    = r_spi_pend ? r_pend_we   : w_new_we;
    assign w_spi_addr  = r_spi_pend ? r_pend_addr : w_new_addr;
    assign w_spi_wdata = r_spi_pend ? r_pend_data : w_pl;

    assign w_spi_grant = (r_state == c_ST_IDLE) && (w_next == c_ST_SPI_ACC);
    assign w_loc_grant = (r_state == c_ST_IDLE) && (w_next == c_ST_LOC_ACC);
    assign w_ret       = (r_state == c_ST_RD_RET);

    // A word arriving while one is still pending is lost unless the pending one
    // leaves this very cycle, in which case the new word takes its slot.
    assign w_drop  = w_accept & r_spi_pend & ~w_spi_grant;
    assign w_keep  = w_accept & ~w_drop;
    assign w_store = w_keep & w_op[0] & (r_spi_pend | ~w_spi_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE: begin
                if (w_spi_req && (!loc_req || !r_last_spi)) begin
                    w_next = c_ST_SPI_ACC;
                end else if (loc_req) begin
                    w_next = c_ST_LOC_ACC;
                end else begin
                    w_next = c_ST_IDLE;
                end
            end
            c_ST_SPI_ACC, c_ST_LOC_ACC: w_next = r_ram_we ? c_ST_IDLE : c_ST_RD_RET;
            c_ST_RD_RET:  w_next = c_ST_IDLE;
            default:      w_next = c_ST_IDLE;
        endcase
    end

    // RAM strobes are loaded on the grant edge so they appear in the ACC state
    always_comb begin
        w_ram_en_d    = w_spi_grant | w_loc_grant;
        w_ram_we_d    = 1'b0;
        w_ram_addr_d  = r_ram_addr;
        w_ram_wdata_d = r_ram_wdata;
        if (w_spi_grant) begin
            w_ram_we_d    = w_spi_we;
            w_ram_addr_d  = w_spi_addr;
            w_ram_wdata_d = w_spi_wdata;
        end else if (w_loc_grant) begin
            w_ram_we_d    = loc_we;
            w_ram_addr_d  = loc_addr;
            w_ram_wdata_d = loc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_q         <= 1'b0;
            r_wr_addr      <= '0;
            r_rd_addr      <= '0;
            r_spi_pend     <= 1'b0;
            r_pend_we      <= 1'b0;
            r_pend_addr    <= '0;
            r_pend_data    <= '0;
            r_spi_ovf      <= 1'b0;
            r_last_spi     <= 1'b0;
            r_owner_spi    <= 1'b0;
            r_ram_en       <= 1'b0;
            r_ram_we       <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_wdata    <= '0;
            r_loc_gnt      <= 1'b0;
            r_loc_rdata    <= '0;
            r_loc_rvalid   <= 1'b0;
            r_spi_tx_data  <= '0;
            r_spi_tx_valid <= 1'b0;
        end else begin
            r_rx_q <= spi_rx_valid;
            if (w_keep && (w_op == c_OP_WADDR)) r_wr_addr <= w_pl_addr;
            if (w_keep && (w_op == c_OP_RADDR)) r_rd_addr <= w_pl_addr;

            if (w_store) begin
                r_spi_pend  <= 1'b1;
                r_pend_we   <= w_new_we;
                r_pend_addr <= w_new_addr;
                r_pend_data <= w_pl;
            end else if (w_spi_grant) begin
                r_spi_pend <= 1'b0;
            end

            if (w_drop) r_spi_ovf <= 1'b1;

            if (w_spi_grant || w_loc_grant) begin
                r_last_spi  <= w_spi_grant;
                r_owner_spi <= w_spi_grant;
            end

            r_ram_en     <= w_ram_en_d;
            r_ram_we     <= w_ram_we_d;
            r_ram_addr   <= w_ram_addr_d;
            r_ram_wdata  <= w_ram_wdata_d;
            r_loc_gnt    <= w_loc_grant;
            r_loc_rvalid <= w_ret & ~r_owner_spi;
            if (w_ret && !r_owner_spi) r_loc_rdata <= ram_rdata;

            // Returned SPI data stays valid until the master sends its next word
            if (w_ret && r_owner_spi) begin
                r_spi_tx_data  <= ram_rdata;
                r_spi_tx_valid <= 1'b1;
            end else if (w_accept) begin
                r_spi_tx_valid <= 1'b0;
            end
        end
    end

    a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
        r_ram_en |-> (int'(r_ram_addr) < MEM_DEPTH));

    assign spi_tx_data  = r_spi_tx_data;
    assign spi_tx_valid = r_spi_tx_valid;
    assign spi_ovf      = r_spi_ovf;
    assign loc_gnt      = r_loc_gnt;
    assign loc_rdata    = r_loc_rdata;
    assign loc_rvalid   = r_loc_rvalid;
    assign ram_en       = r_ram_en;
    assign ram_we       = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_port_arbiter
// Brief   : Directed cycle-table and corner-case bench for ram_port_arbiter
//           with a behavioural single-port RAM.
// Revision: 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int c_AW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [9:0]      spi_rx_data = '0;
    logic            spi_rx_valid = 1'b0;
    logic [7:0]      spi_tx_data;
    logic            spi_tx_valid;
    logic            spi_ovf;
    logic            loc_req = 1'b0;
    logic            loc_we = 1'b0;
    logic [c_AW-1:0] loc_addr = '0;
    logic [7:0]      loc_wdata = '0;
    logic            loc_gnt;
    logic [7:0]      loc_rdata;
    logic            loc_rvalid;
    logic            ram_en;
    logic            ram_we;
    logic [c_AW-1:0] ram_addr;
    logic [7:0]      ram_wdata;
    logic [7:0]      ram_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;
    int ee_cnt   = 0;
    int w44_cnt  = 0;
    int rv_cnt   = 0;

    logic [7:0] mem [256];

    ram_port_arbiter #(.ADDR_SIZE(c_AW), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .spi_ovf(spi_ovf),
        .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .loc_rvalid(loc_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
        if (ram_en && ram_we && ram_wdata == 8'hEE) ee_cnt <= ee_cnt + 1;
        if (ram_en && ram_we && ram_addr == 8'h00 && ram_wdata == 8'h44) w44_cnt <= w44_cnt + 1;
        if (loc_rvalid) rv_cnt <= rv_cnt + 1;
    end

    typedef struct {
        logic       v;
        logic [9:0] d;
        logic       lreq, lwe;
        logic [7:0] la, lwd;
        logic       en, we;
        logic [7:0] a, wd;
        logic       gnt, rv;
        logic [7:0] rd;
        logic       txv;
        logic [7:0] txd;
        logic       ovf;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [9:0] d, input logic lreq,
                                input logic lwe, input logic [7:0] la, input logic [7:0] lwd,
                                input logic en, input logic we, input logic [7:0] a,
                                input logic [7:0] wd, input logic gnt, input logic rv,
                                input logic [7:0] rd, input logic txv, input logic [7:0] txd,
                                input logic ovf);
        vec_t r;
        r.v = v; r.d = d; r.lreq = lreq; r.lwe = lwe; r.la = la; r.lwd = lwd;
        r.en = en; r.we = we; r.a = a; r.wd = wd; r.gnt = gnt; r.rv = rv;
        r.rd = rd; r.txv = txv; r.txd = txd; r.ovf = ovf;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] all_outs();
        return {spi_tx_data, spi_tx_valid, spi_ovf, loc_gnt, loc_rdata, loc_rvalid,
                ram_en, ram_we, ram_addr, ram_wdata};
    endfunction

    vec_t vecs [24];

    initial begin
        int rv0, w0;
        logic [37:0] obs, exp;

        // Each row: inputs held for one cycle, outputs expected right after that edge
        vecs[0]  = mk(1, 10'h005, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[1]  = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[2]  = mk(1, 10'h1A5, 0, 0, 8'h00, 8'h00, 1, 1, 8'h05, 8'hA5, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[3]  = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[4]  = mk(1, 10'h205, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[5]  = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[6]  = mk(1, 10'h305, 0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[7]  = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[8]  = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0);
        vecs[9]  = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0);
        vecs[10] = mk(0, 10'h000, 1, 1, 8'h10, 8'h3C, 1, 1, 8'h10, 8'h3C, 1, 0, 8'h00, 1, 8'hA5, 0);
        vecs[11] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0);
        vecs[12] = mk(0, 10'h000, 1, 0, 8'h10, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0, 8'h00, 1, 8'hA5, 0);
        vecs[13] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0);
        vecs[14] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'h3C, 1, 8'hA5, 0);
        vecs[15] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0);
        vecs[16] = mk(1, 10'h177, 1, 1, 8'h20, 8'h11, 1, 1, 8'h05, 8'h77, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[17] = mk(0, 10'h000, 1, 1, 8'h20, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[18] = mk(0, 10'h000, 1, 1, 8'h20, 8'h11, 1, 1, 8'h20, 8'h11, 1, 0, 8'h00, 0, 8'h00, 0);
        vecs[19] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[20] = mk(1, 10'h188, 1, 1, 8'h21, 8'h22, 1, 1, 8'h05, 8'h88, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[21] = mk(0, 10'h000, 1, 1, 8'h21, 8'h22, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[22] = mk(0, 10'h000, 1, 1, 8'h21, 8'h22, 1, 1, 8'h21, 8'h22, 1, 0, 8'h00, 0, 8'h00, 0);
        vecs[23] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check("reset_outputs", all_outs(), 38'h0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            spi_rx_valid = vecs[i].v;  spi_rx_data = vecs[i].d;
            loc_req = vecs[i].lreq;    loc_we = vecs[i].lwe;
            loc_addr = vecs[i].la;     loc_wdata = vecs[i].lwd;
            tick();
            obs = {ram_en, ram_we, vecs[i].en ? ram_addr : 8'h00,
                   (vecs[i].en && vecs[i].we) ? ram_wdata : 8'h00,
                   loc_gnt, loc_rvalid, vecs[i].rv ? loc_rdata : 8'h00,
                   spi_tx_valid, vecs[i].txv ? spi_tx_data : 8'h00, spi_ovf};
            exp = {vecs[i].en, vecs[i].we, vecs[i].en ? vecs[i].a : 8'h00,
                   (vecs[i].en && vecs[i].we) ? vecs[i].wd : 8'h00,
                   vecs[i].gnt, vecs[i].rv, vecs[i].rv ? vecs[i].rd : 8'h00,
                   vecs[i].txv, vecs[i].txv ? vecs[i].txd : 8'h00, vecs[i].ovf};
            check($sformatf("row%0d", i), obs, exp);
        end

        // Overflow: local wins a tie after an SPI grant, SPI word pends, next word dropped
        spi_rx_valid = 1'b1; spi_rx_data = 10'h199; tick();
        spi_rx_valid = 1'b0; tick();
        spi_rx_valid = 1'b1; spi_rx_data = 10'h155;
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h10; tick();
        check("tie_local_gnt", {loc_gnt, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 1'b0, 8'h10});
        spi_rx_valid = 1'b0; loc_req = 1'b0; tick();
        spi_rx_valid = 1'b1; spi_rx_data = 10'h1EE; tick();
        check("ovf_set", spi_ovf, 1);
        check("ovf_loc_rdata", {loc_rvalid, loc_rdata}, {1'b1, 8'h3C});
        spi_rx_valid = 1'b0; tick();
        check("pend_write", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 8'h05, 8'h55});
        tick(); tick(); tick();
        check("dropped_never_written", ee_cnt, 0);
        check("pend_data_in_ram", mem[5], 8'h55);
        check("ovf_sticky", spi_ovf, 1);

        // Reset in LOC_ACC of a read, with rx_valid held high through reset
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h10; tick();
        check("pre_rst_gnt", loc_gnt, 1);
        rst = 1'b1; loc_req = 1'b0; spi_rx_valid = 1'b1; spi_rx_data = 10'h144; tick();
        check("rst_mid_outputs", all_outs(), 38'h0);
        tick();
        rv0 = rv_cnt; w0 = w44_cnt;
        rst = 1'b0;
        repeat (6) tick();
        check("rst_no_rvalid", rv_cnt - rv0, 0);
        check("rst_no_txv_ovf", {spi_tx_valid, spi_ovf}, 2'b00);
        check("held_valid_once", w44_cnt - w0, 1);
        spi_rx_valid = 1'b0;
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h10; tick();
        check("post_rst_gnt", loc_gnt, 1);
        loc_req = 1'b0; tick(); tick();
        check("post_rst_rdata", {loc_rvalid, loc_rdata}, {1'b1, 8'h3C});

        // Top address 0xFF from both ports
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'hFF; loc_wdata = 8'h5A; tick();
        check("ff_loc_write", {loc_gnt, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 1'b1, 8'hFF});
        loc_req = 1'b0; tick();
        loc_req = 1'b1; loc_we = 1'b0; tick();
        loc_req = 1'b0; tick(); tick();
        check("ff_loc_rdata", {loc_rvalid, loc_rdata}, {1'b1, 8'h5A});
        spi_rx_valid = 1'b1; spi_rx_data = 10'h2FF; tick();
        spi_rx_valid = 1'b0; tick();
        spi_rx_valid = 1'b1; spi_rx_data = 10'h3FF; tick();
        check("ff_spi_read", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'hFF});
        spi_rx_valid = 1'b0; tick(); tick();
        check("ff_spi_tx", {spi_tx_valid, spi_tx_data}, {1'b1, 8'h5A});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
